// File: rtl/peripheral_responder.sv
// Peripheral endpoint for the core's to_peripheral/from_peripheral command port.
// Decodes NOP/WRITE/READ/STATUS, answers each command with one registered
// response, and buffers outbound (TX) and inbound (RX) words in two FIFOs.
module peripheral_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            to_peripheral,
    input  logic [DATA_WIDTH-1:0] to_peripheral_data,
    input  logic                  to_peripheral_valid,
    output logic [1:0]            from_peripheral,
    output logic [DATA_WIDTH-1:0] from_peripheral_data,
    output logic                  from_peripheral_valid,
    input  logic [DATA_WIDTH-1:0] ext_in_data,
    input  logic                  ext_in_valid,
    output logic                  ext_in_ready,
    output logic [DATA_WIDTH-1:0] ext_out_data,
    output logic                  ext_out_valid,
    input  logic                  ext_out_ready
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_STATUS = 2'b11;

    localparam logic [1:0] RSP_IDLE = 2'b00;
    localparam logic [1:0] RSP_ACK  = 2'b01;
    localparam logic [1:0] RSP_DATA = 2'b10;
    localparam logic [1:0] RSP_ERR  = 2'b11;

    logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CNT_W-1:0]      tx_count, rx_count;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;

    logic [1:0]            rsp_code_next;
    logic [DATA_WIDTH-1:0] rsp_data_next;
    logic                  rsp_valid_next;

    // FIFO flags come from registered counts only
    assign tx_full  = (tx_count == FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == FULL_CNT);
    assign rx_empty = (rx_count == '0);

    assign ext_in_ready  = !rx_full;
    assign ext_out_valid = !tx_empty;
    assign ext_out_data  = tx_mem[tx_rd_ptr];

    // FIFO handshakes; command-side decisions use pre-edge fullness
    assign tx_push = to_peripheral_valid && (to_peripheral == OP_WRITE) && !tx_full;
    assign tx_pop  = !tx_empty && ext_out_ready;
    assign rx_push = ext_in_valid && !rx_full;
    assign rx_pop  = to_peripheral_valid && (to_peripheral == OP_READ) && !rx_empty;

    // Response decode for the command presented this cycle
    always_comb begin
        rsp_code_next  = RSP_IDLE;
        rsp_data_next  = '0;
        rsp_valid_next = 1'b0;
        if (to_peripheral_valid) begin
            rsp_valid_next = 1'b1;
            case (to_peripheral)
                OP_NOP: begin
                    rsp_code_next = RSP_ACK;
                end
                OP_WRITE: begin
                    if (!tx_full) begin
                        rsp_code_next = RSP_ACK;
                        rsp_data_next = DATA_WIDTH'(tx_count + CNT_W'(1));
                    end else begin
                        rsp_code_next = RSP_ERR;
                        rsp_data_next = DATA_WIDTH'(1);
                    end
                end
                OP_READ: begin
                    if (!rx_empty) begin
                        rsp_code_next = RSP_DATA;
                        rsp_data_next = rx_mem[rx_rd_ptr];
                    end else begin
                        rsp_code_next = RSP_ERR;
                        rsp_data_next = DATA_WIDTH'(2);
                    end
                end
                OP_STATUS: begin
                    rsp_code_next = RSP_ACK;
                    rsp_data_next = DATA_WIDTH'({8'(rx_count), 8'(tx_count)});
                end
                default: begin
                    rsp_code_next = RSP_IDLE;
                end
            endcase
        end
    end

    // Response register: one-cycle latency, cleared on reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            from_peripheral       <= RSP_IDLE;
            from_peripheral_data  <= '0;
            from_peripheral_valid <= 1'b0;
        end else begin
            from_peripheral       <= rsp_code_next;
            from_peripheral_data  <= rsp_data_next;
            from_peripheral_valid <= rsp_valid_next;
        end
    end

    // TX FIFO: filled by WRITE commands, drained by the external sink
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem[i] <= '0;
            end
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr_ptr] <= to_peripheral_data;
                tx_wr_ptr         <= tx_wr_ptr + PTR_W'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
            end
            tx_count <= tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);
        end
    end

    // RX FIFO: filled by the external source, drained by READ commands
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                rx_mem[i] <= '0;
            end
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr_ptr] <= ext_in_data;
                rx_wr_ptr         <= rx_wr_ptr + PTR_W'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
            end
            rx_count <= rx_count + CNT_W'(rx_push) - CNT_W'(rx_pop);
        end
    end

endmodule

// File: tb/tb_peripheral_responder.sv
// Self-checking bench for peripheral_responder: expected responses are queued
// when a command is driven and compared by a monitor when the response is due.
module tb_peripheral_responder;

    localparam int unsigned DW = 32;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_STATUS = 2'b11;
    localparam logic [1:0] RSP_ACK   = 2'b01;
    localparam logic [1:0] RSP_DATA  = 2'b10;
    localparam logic [1:0] RSP_ERR   = 2'b11;

    typedef struct packed {
        logic [1:0]    code;
        logic [DW-1:0] data;
        int            due;
    } resp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    to_peripheral = '0;
    logic [DW-1:0] to_peripheral_data = '0;
    logic          to_peripheral_valid = 1'b0;
    logic [1:0]    from_peripheral;
    logic [DW-1:0] from_peripheral_data;
    logic          from_peripheral_valid;
    logic [DW-1:0] ext_in_data = '0;
    logic          ext_in_valid = 1'b0;
    logic          ext_in_ready;
    logic [DW-1:0] ext_out_data;
    logic          ext_out_valid;
    logic          ext_out_ready = 1'b0;

    int    checks = 0;
    int    fails  = 0;
    int    cyc    = 0;
    resp_t sb[$];
    resp_t mon_exp;

    peripheral_responder #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .to_peripheral         (to_peripheral),
        .to_peripheral_data    (to_peripheral_data),
        .to_peripheral_valid   (to_peripheral_valid),
        .from_peripheral       (from_peripheral),
        .from_peripheral_data  (from_peripheral_data),
        .from_peripheral_valid (from_peripheral_valid),
        .ext_in_data           (ext_in_data),
        .ext_in_valid          (ext_in_valid),
        .ext_in_ready          (ext_in_ready),
        .ext_out_data          (ext_out_data),
        .ext_out_valid         (ext_out_valid),
        .ext_out_ready         (ext_out_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Response monitor: compare against the scoreboard head when it is due,
    // otherwise require an idle response port
    always @(negedge clock) begin
        if (!reset) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_exp = sb.pop_front();
                checks++;
                if (from_peripheral_valid !== 1'b1 || from_peripheral !== mon_exp.code ||
                    from_peripheral_data !== mon_exp.data) begin
                    fails++;
                    $display("FAIL resp @cyc %0d: got valid=%0b code=%0d data=%h, want valid=1 code=%0d data=%h",
                             cyc, from_peripheral_valid, from_peripheral, from_peripheral_data,
                             mon_exp.code, mon_exp.data);
                end
            end else begin
                checks++;
                if (from_peripheral_valid !== 1'b0 || from_peripheral !== 2'b00 ||
                    from_peripheral_data !== '0) begin
                    fails++;
                    $display("FAIL idle_resp @cyc %0d: got valid=%0b code=%0d data=%h, want all zero",
                             cyc, from_peripheral_valid, from_peripheral, from_peripheral_data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one command for one cycle and queue its expected response
    task automatic send(input logic [1:0] op, input logic [DW-1:0] d,
                        input logic [1:0] ec, input logic [DW-1:0] ed);
        resp_t e;
        e.code = ec;
        e.data = ed;
        e.due  = cyc + 1;
        sb.push_back(e);
        to_peripheral       = op;
        to_peripheral_data  = d;
        to_peripheral_valid = 1'b1;
        tick();
        to_peripheral_valid = 1'b0;
        to_peripheral       = '0;
        to_peripheral_data  = '0;
    endtask

    task automatic drain_check(input string name);
        tick();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d responses outstanding, want 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (from_peripheral_valid !== 1'b0 || from_peripheral !== 2'b00 || from_peripheral_data !== '0) begin
            fails++;
            $display("FAIL reset_resp: got valid=%0b code=%0d data=%h, want zeros",
                     from_peripheral_valid, from_peripheral, from_peripheral_data);
        end
        checks++;
        if (ext_out_valid !== 1'b0 || ext_out_data !== '0) begin
            fails++;
            $display("FAIL reset_tx: got valid=%0b data=%h, want 0/0", ext_out_valid, ext_out_data);
        end
        checks++;
        if (ext_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %0b, want 1", ext_in_ready);
        end
        reset = 1'b0;
        send(OP_STATUS, '0, RSP_ACK, 32'h0);
        send(OP_NOP, 32'hDEAD_BEEF, RSP_ACK, 32'h0);
        drain_check("reset");
    endtask

    task automatic test_write();
        ext_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(OP_WRITE, 32'hA0 + DW'(i), RSP_ACK, DW'(i + 1));
        end
        send(OP_WRITE, 32'hA4, RSP_ERR, 32'h1);
        checks++;
        if (ext_out_valid !== 1'b1 || ext_out_data !== 32'hA0) begin
            fails++;
            $display("FAIL tx_head: got valid=%0b data=%h, want 1/000000a0", ext_out_valid, ext_out_data);
        end
        ext_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ext_out_valid !== 1'b1 || ext_out_data !== 32'hA0 + DW'(i)) begin
                fails++;
                $display("FAIL tx_sink[%0d]: got valid=%0b data=%h, want 1/%h",
                         i, ext_out_valid, ext_out_data, 32'hA0 + DW'(i));
            end
            tick();
        end
        ext_out_ready = 1'b0;
        checks++;
        if (ext_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL tx_empty: got valid=%0b, want 0", ext_out_valid);
        end
        drain_check("write");
    endtask

    task automatic test_read();
        ext_in_valid = 1'b1;
        ext_in_data  = 32'h11;
        tick();
        ext_in_data  = 32'h22;
        tick();
        ext_in_valid = 1'b0;
        send(OP_READ, '0, RSP_DATA, 32'h11);
        send(OP_READ, '0, RSP_DATA, 32'h22);
        send(OP_READ, '0, RSP_ERR, 32'h2);
        send(OP_STATUS, '0, RSP_ACK, 32'h0);
        drain_check("read");
    endtask

    task automatic test_rx_full();
        ext_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ext_in_data = 32'h30 + DW'(i);
            tick();
        end
        checks++;
        if (ext_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rx_full_ready: got %0b, want 0", ext_in_ready);
        end
        ext_in_data = 32'h34;
        tick();
        checks++;
        if (ext_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rx_held_ready: got %0b, want 0", ext_in_ready);
        end
        send(OP_READ, '0, RSP_DATA, 32'h30);
        checks++;
        if (ext_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rx_reopen_ready: got %0b, want 1", ext_in_ready);
        end
        tick();
        ext_in_valid = 1'b0;
        checks++;
        if (ext_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rx_refill_ready: got %0b, want 0", ext_in_ready);
        end
        send(OP_STATUS, '0, RSP_ACK, 32'h0000_0400);
        for (int i = 1; i < 5; i++) begin
            send(OP_READ, '0, RSP_DATA, 32'h30 + DW'(i));
        end
        send(OP_READ, '0, RSP_ERR, 32'h2);
        drain_check("rx_full");
    endtask

    task automatic test_simultaneous();
        ext_in_valid = 1'b1;
        ext_in_data  = 32'h44;
        tick();
        ext_in_data  = 32'h55;
        send(OP_READ, '0, RSP_DATA, 32'h44);
        ext_in_valid = 1'b0;
        send(OP_STATUS, '0, RSP_ACK, 32'h0000_0100);
        send(OP_READ, '0, RSP_DATA, 32'h55);
        ext_in_valid = 1'b1;
        ext_in_data  = 32'h66;
        send(OP_READ, '0, RSP_ERR, 32'h2);
        ext_in_valid = 1'b0;
        send(OP_STATUS, '0, RSP_ACK, 32'h0000_0100);
        send(OP_READ, '0, RSP_DATA, 32'h66);
        ext_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(OP_WRITE, 32'h90 + DW'(i), RSP_ACK, DW'(i + 1));
        end
        ext_out_ready = 1'b1;
        send(OP_WRITE, 32'h99, RSP_ERR, 32'h1);
        ext_out_ready = 1'b0;
        checks++;
        if (ext_out_data !== 32'h91) begin
            fails++;
            $display("FAIL tx_head_after_pop: got %h, want 00000091", ext_out_data);
        end
        send(OP_STATUS, '0, RSP_ACK, 32'h0000_0003);
        drain_check("simultaneous");
    endtask

    task automatic test_reset_mid();
        ext_out_ready = 1'b1;
        tick();
        ext_out_ready = 1'b0;
        checks++;
        if (ext_out_valid !== 1'b1 || ext_out_data !== 32'h92) begin
            fails++;
            $display("FAIL mid_pre_tx: got valid=%0b data=%h, want 1/00000092", ext_out_valid, ext_out_data);
        end
        to_peripheral       = OP_STATUS;
        to_peripheral_valid = 1'b1;
        tick();
        to_peripheral_valid = 1'b0;
        to_peripheral       = '0;
        reset = 1'b1;
        sb.delete();
        #1;
        checks++;
        if (from_peripheral_valid !== 1'b0 || from_peripheral !== 2'b00 || from_peripheral_data !== '0) begin
            fails++;
            $display("FAIL mid_resp: got valid=%0b code=%0d data=%h, want zeros",
                     from_peripheral_valid, from_peripheral, from_peripheral_data);
        end
        checks++;
        if (ext_out_valid !== 1'b0 || ext_out_data !== '0 || ext_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_fifo: got out_valid=%0b out_data=%h in_ready=%0b, want 0/0/1",
                     ext_out_valid, ext_out_data, ext_in_ready);
        end
        tick();
        tick();
        reset = 1'b0;
        send(OP_STATUS, '0, RSP_ACK, 32'h0);
        send(OP_READ, '0, RSP_ERR, 32'h2);
        drain_check("reset_mid");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_rx_full();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/peripheral_responder.md
# peripheral_responder

Peripheral-side endpoint of the core's `to_peripheral` / `from_peripheral` I/O interface. It decodes 2-bit commands issued by `RISC_V_Core` and returns exactly one registered response per command. It buffers outbound words in a TX FIFO drained by an external sink, and inbound words in an RX FIFO filled by an external source. It sits beside the core in the top level and in instruction/IO testbenches, replacing the stubbed `from_peripheral*` drivers.

## Interface
- `DATA_WIDTH`, 32, width of command/response data and FIFO words.
- `FIFO_DEPTH`, 4, entries per FIFO; power of two, 2..128.
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `to_peripheral`  in  2  command opcode from core: 00 NOP, 01 WRITE, 10 READ, 11 STATUS.
- `to_peripheral_data`  in  DATA_WIDTH  WRITE payload; ignored for other opcodes.
- `to_peripheral_valid`  in  1  command strobe; one command per high cycle.
- `from_peripheral`  out  2  response code: 00 idle, 01 ACK, 10 DATA, 11 ERR.
- `from_peripheral_data`  out  DATA_WIDTH  response payload.
- `from_peripheral_valid`  out  1  response strobe.
- `ext_in_data`  in  DATA_WIDTH  word from external source into RX FIFO.
- `ext_in_valid`  in  1  source has a word.
- `ext_in_ready`  out  1  RX FIFO not full.
- `ext_out_data`  out  DATA_WIDTH  TX FIFO head word.
- `ext_out_valid`  out  1  TX FIFO not empty.
- `ext_out_ready`  in  1  sink accepts head word.

## Operation
- The core has no backpressure. Every cycle with `to_peripheral_valid`=1 is a command. Failures are reported as ERR and never stall.
- All decisions use FIFO state as it stood before the current edge (pre-update counts).
- NOP: response ACK, data 0.
- WRITE:
  - If TX is not full, push `to_peripheral_data`. Response ACK, data = TX count after the push, zero-extended.
  - If TX is full, no push. Response ERR, data 1.
- READ:
  - If RX is not empty, pop the head. Response DATA, data = popped word.
  - If RX is empty, no pop. Response ERR, data 2.
- STATUS: response ACK; data[7:0] = TX count, data[15:8] = RX count, upper bits 0. Both are pre-edge values.
- RX FIFO:
  - Push when `ext_in_valid` && `ext_in_ready`.
  - `ext_in_ready` = !rx_full, driven from registered count only (no combinational path from inputs).
- TX FIFO:
  - `ext_out_valid` = !tx_empty; `ext_out_data` = head entry.
  - Pop when `ext_out_valid` && `ext_out_ready`.
- FIFO storage:
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - Count is log2(FIFO_DEPTH)+1 bits, updated as count + push − pop.
- Simultaneous events:
  - RX push and READ pop in the same cycle: both take effect and count is unchanged. A READ on empty RX errors while the push still lands.
  - WRITE to full TX in the same cycle as an external pop: the WRITE errors, because fullness is pre-edge.
  - Push and pop on a full FIFO: RX push is blocked by ready. A TX push on full errors as above.
- Reset, asynchronous, including mid-operation:
  - Both FIFOs become empty and pointers/counts go to 0.
  - `from_peripheral`=00, `from_peripheral_data`=0, `from_peripheral_valid`=0, `ext_out_valid`=0, `ext_out_data`=0 (head of cleared storage).
  - `ext_in_ready`=1.
  - A pending response is discarded.

## Timing
- Response latency is exactly 1 cycle: a command sampled at edge N produces `from_peripheral*` valid during cycle N to N+1.
- Back-to-back commands produce back-to-back responses with no bubble, one response per command, in order.
- In a cycle with no response: `from_peripheral_valid`=0, `from_peripheral`=00, `from_peripheral_data`=0.
- A WRITE's pushed word is visible on `ext_out_data` / `ext_out_valid` the cycle after the edge. It is never bypassed into the same cycle.
- An RX word pushed at edge N is readable by a READ sampled at edge N+1 or later.
- `ext_in_ready` deasserts the cycle after the push that fills RX.

## Test plan
- Reset release: hold `reset` for 5 cycles, then release.
  - All outputs at reset values; `ext_in_ready`=1.
  - STATUS returns ACK, data 0x0000_0000.
- WRITE path: `ext_out_ready`=0; WRITE 0xA0, 0xA1, 0xA2, 0xA3, then 0xA4.
  - ACKs with data 1, 2, 3, 4, then ERR data 1.
  - Raise `ext_out_ready`: sink receives 0xA0..0xA3 in order, then `ext_out_valid`=0.
- READ path: source pushes 0x11, 0x22; then READ ×3.
  - DATA 0x11, DATA 0x22, then ERR data 2.
  - STATUS afterwards shows RX count 0.
- RX full/backpressure: push 4 words with no READs.
  - `ext_in_ready`=0 the next cycle; a 5th word is held by the source.
  - One READ returns word 0; `ext_in_ready` is 1 again the cycle after.
- Simultaneous events:
  - RX holds 1 word; issue READ while the source pushes 0x55 in the same cycle: DATA returns the old word and RX count stays 1.
  - TX full, WRITE 0x99 while the sink pops: ERR data 1, TX count becomes 3.
- Reset mid-stream: assert `reset` while TX holds 2 words and a response is pending.
  - Immediately `ext_out_valid`=0 and `from_peripheral_valid`=0.
  - After release, STATUS returns ACK, data 0.
